// File: rtl/vact_pkg.sv
// Shared types and defaults for the vector activation pipeline.
// Mode encoding, default geometry and the per-lane stage-1 record.
package vact_pkg;

   localparam int VACT_W     = 8;
   localparam int VACT_LANES = 4;
   localparam int VACT_SHW   = 3;
   localparam int VACT_CNT_W = 16;

   typedef enum logic [1:0] {
      VACT_PASS  = 2'b00,
      VACT_RELU  = 2'b01,
      VACT_BRELU = 2'b10,
      VACT_LEAKY = 2'b11
   } vact_mode_e;

   typedef struct packed {
      logic [VACT_W-1:0] a;
      logic              neg;
      logic              over;
      logic [VACT_W-1:0] shifted;
   } vact_s1_t;

endpackage

// File: rtl/vact_relu_pipe_if.sv
// Valid/ready element stream used around the activation pipeline.
// The producer drives valid/data, the consumer drives ready.
interface vact_if #(
   parameter int W     = 8,
   parameter int LANES = 4
);

   logic               valid;
   logic               ready;
   logic [LANES*W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vact_lane.sv
// One activation lane: stage-1 compare/shift and stage-2 result select.
// Purely combinational; the top owns all pipeline registers.
module vact_lane
   import vact_pkg::*;
#(
   parameter int W   = VACT_W,
   parameter int SHW = VACT_SHW
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-2:0]   bound_i,
   input  logic [SHW-1:0] shift_i,
   output vact_s1_t       s1_o,
   input  vact_s1_t       s1_i,
   input  vact_mode_e     mode_i,
   input  logic [W-2:0]   s1_bound_i,
   input  logic           act_i,
   output logic [W-1:0]   r_o,
   output logic           mod_o
);

   always_comb begin
      s1_o.a       = a_i;
      s1_o.neg     = a_i[W-1];
      s1_o.over    = $signed(a_i) > $signed({1'b0, bound_i});
      s1_o.shifted = $signed(a_i) >>> shift_i;
   end

   // Inactive lanes pass through and are never reported as modified.
   always_comb begin
      r_o = s1_i.a;
      if (act_i) begin
         unique case (mode_i)
            VACT_PASS:  r_o = s1_i.a;
            VACT_RELU:  if (s1_i.neg) r_o = '0;
            VACT_BRELU: begin
               if (s1_i.neg)       r_o = '0;
               else if (s1_i.over) r_o = {1'b0, s1_bound_i};
            end
            VACT_LEAKY: if (s1_i.neg) r_o = s1_i.shifted;
            default:    r_o = s1_i.a;
         endcase
      end
      mod_o = act_i && (r_o != s1_i.a);
   end

endmodule

// File: rtl/vact_relu_pipe.sv
// Two-stage elastic multi-lane activation unit with profiling counter.
// Stage 1 holds compare/shift flags, stage 2 holds the final results.
module vact_relu_pipe
   import vact_pkg::*;
#(
   parameter int W     = VACT_W,
   parameter int LANES = VACT_LANES,
   parameter int SHW   = VACT_SHW,
   parameter int CNT_W = VACT_CNT_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [LANES*W-1:0] in_data_i,
   input  logic [LANES-1:0]   in_mask_i,
   input  logic [1:0]         mode_i,
   input  logic [W-2:0]       bound_i,
   input  logic [SHW-1:0]     shift_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [LANES*W-1:0] out_data_o,
   input  logic               cnt_clr_i,
   output logic [CNT_W-1:0]   mod_cnt_o
);

   localparam int PCW = $clog2(LANES + 1);

   logic rdy_q, rdy_d;
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_adv, s2_adv, in_fire, s2_load, out_fire;

   vact_s1_t [LANES-1:0] s1_nx, s1_q, s1_d;
   vact_mode_e           mode_q, mode_d;
   logic [W-2:0]         bound_q, bound_d;
   logic [LANES-1:0]     mask_q, mask_d;

   logic [LANES*W-1:0] res, out_q, out_d;
   logic [LANES-1:0]   lmod;
   logic [PCW-1:0]     pop, pc_q, pc_d;
   logic [CNT_W:0]     sum;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      vact_lane #(.W(W), .SHW(SHW)) u_lane (
         .a_i        (in_data_i[k*W +: W]),
         .bound_i    (bound_i),
         .shift_i    (shift_i),
         .s1_o       (s1_nx[k]),
         .s1_i       (s1_q[k]),
         .mode_i     (mode_q),
         .s1_bound_i (bound_q),
         .act_i      (mask_q[k]),
         .r_o        (res[k*W +: W]),
         .mod_o      (lmod[k])
      );
   end

   // ready from downstream may ripple straight back to in_ready_o
   always_comb begin
      s2_adv     = !s2_valid_q || out_ready_i;
      s1_adv     = !s1_valid_q || s2_adv;
      in_ready_o = rdy_q && s1_adv;
      in_fire    = in_valid_i && in_ready_o;
      s2_load    = s2_adv && s1_valid_q;
      out_fire   = s2_valid_q && out_ready_i;
   end

   always_comb begin
      pop = '0;
      for (int k = 0; k < LANES; k++) begin
         pop = pop + PCW'(lmod[k]);
      end
   end

   always_comb begin
      rdy_d      = 1'b1;
      s1_valid_d = s1_adv ? in_fire : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      s1_d       = in_fire ? s1_nx : s1_q;
      mode_d     = in_fire ? vact_mode_e'(mode_i) : mode_q;
      bound_d    = in_fire ? bound_i : bound_q;
      mask_d     = in_fire ? in_mask_i : mask_q;
      out_d      = s2_load ? res : out_q;
      pc_d       = s2_load ? pop : pc_q;
   end

   // clear wins over a same-cycle increment; saturate instead of wrapping
   always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_W+1)'(pc_q);
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (out_fire) begin
         cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         mode_q     <= VACT_PASS;
         bound_q    <= '0;
         mask_q     <= '0;
         out_q      <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
      end else begin
         rdy_q      <= rdy_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         mode_q     <= mode_d;
         bound_q    <= bound_d;
         mask_q     <= mask_d;
         out_q      <= out_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid_o = s2_valid_q;
   assign out_data_o  = out_q;
   assign mod_cnt_o   = cnt_q;

endmodule

// File: tb/tb_vact_relu_pipe.sv
// Scoreboard bench for vact_relu_pipe (4 lanes x 8 bits, 4-bit counter).
// Driver queues hand-computed results; a negedge monitor checks them.
module tb_vact_relu_pipe;

   typedef struct {
      logic [31:0] d;
      int          mods;
      int          acc;
      bit          lat;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [3:0] in_mask = 4'hF;
   logic [1:0] mode = 2'b00;
   logic [6:0] bound = '0;
   logic [2:0] shift = '0;
   logic       cnt_clr = 1'b0;
   logic [3:0] mod_cnt;

   vact_if #(.W(8), .LANES(4)) in_if ();
   vact_if #(.W(8), .LANES(4)) out_if ();

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   outs_seen = 0;
   int   exp_cnt = 0;
   bit   saw_stall = 0;
   bit   hold_v = 0;
   logic [31:0] hold_d = '0;

   vact_relu_pipe #(.W(8), .LANES(4), .SHW(3), .CNT_W(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_if.valid),
      .in_ready_o  (in_if.ready),
      .in_data_i   (in_if.data),
      .in_mask_i   (in_mask),
      .mode_i      (mode),
      .bound_i     (bound),
      .shift_i     (shift),
      .out_valid_o (out_if.valid),
      .out_ready_i (out_if.ready),
      .out_data_o  (out_if.data),
      .cnt_clr_i   (cnt_clr),
      .mod_cnt_o   (mod_cnt)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_ni) begin
         exp_cnt = 0;
         hold_v  = 0;
      end else begin
         chk("mod_cnt", 32'(mod_cnt), exp_cnt);
         if (hold_v) begin
            chk("hold_valid", 32'(out_if.valid), 1);
            chk("hold_data", out_if.data, hold_d);
         end
         hold_v = out_if.valid && !out_if.ready;
         hold_d = out_if.data;
         if (out_if.valid && out_if.ready) begin
            outs_seen++;
            if (sb.size() == 0) begin
               chk("unexpected_out", out_if.data, 32'hxxxxxxxx);
            end else begin
               e = sb.pop_front();
               chk("out_data", out_if.data, e.d);
               if (e.lat) chk("latency", cyc - e.acc, 2);
               if (cnt_clr) exp_cnt = 0;
               else exp_cnt = (exp_cnt + e.mods > 15) ? 15
                                                      : exp_cnt + e.mods;
            end
         end else if (cnt_clr) begin
            exp_cnt = 0;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [3:0] m,
                       input logic [1:0] md, input logic [6:0] b,
                       input logic [2:0] sh, input logic [31:0] ex,
                       input int mods, input bit lat);
      exp_t e;
      int   n;
      in_if.data  = d;
      in_mask     = m;
      mode        = md;
      bound       = b;
      shift       = sh;
      in_if.valid = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!in_if.ready && n < 200) begin
         saw_stall = 1;
         n++;
         @(negedge clk_i);
      end
      if (!in_if.ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout act=0 exp=1");
      end else begin
         e.d = ex;
         e.mods = mods;
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
      in_if.valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk_i);
         n++;
      end
      chk("drain", sb.size(), 0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      int n;
      int seen;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_if.valid), 0);
      chk("rst_out_data", out_if.data, 0);
      chk("rst_cnt", 32'(mod_cnt), 0);
      chk("rst_in_ready", 32'(in_if.ready), 0);
      #19 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      chk("ready_after_rst", 32'(in_if.ready), 1);

      // directed vectors: data, mask, mode, bound, shift, expected, mods
      send(32'h7F2500FB, 4'hF, 2'b01, 7'd0,  3'd0, 32'h7F250000, 1, 1);
      send(32'h7F605F80, 4'hF, 2'b10, 7'd96, 3'd0, 32'h60605F00, 2, 1);
      send(32'h1480FFF8, 4'hF, 2'b11, 7'd0,  3'd2, 32'h14E0FFFE, 2, 1);
      send(32'hFAFBFCFD, 4'h5, 2'b01, 7'd0,  3'd0, 32'hFA00FC00, 2, 1);
      send(32'h7F0100FF, 4'hF, 2'b10, 7'd0,  3'd0, 32'h00000000, 3, 1);
      send(32'hF905FF80, 4'hF, 2'b11, 7'd0,  3'd0, 32'hF905FF80, 0, 1);
      send(32'h40FEFF80, 4'hF, 2'b11, 7'd0,  3'd7, 32'h40FFFFFF, 2, 1);
      send(32'h807F01FF, 4'hF, 2'b00, 7'd5,  3'd3, 32'h807F01FF, 0, 1);
      drain();
      chk("cnt_after_directed", 32'(mod_cnt), 12);

      cnt_clr = 1'b1;
      @(posedge clk_i);
      #1;
      cnt_clr = 1'b0;
      chk("cnt_idle_clear", 32'(mod_cnt), 0);

      // backpressure; mode flips from ReLU to pass after beat 3
      saw_stall = 0;
      fork
         begin
            for (int i = 0; i < 3; i++)
               send(32'h04FD02FF, 4'hF, 2'b01, 7'd0, 3'd0,
                    32'h04000200, 2, 0);
            for (int i = 0; i < 2; i++)
               send(32'h04FD02FF, 4'hF, 2'b00, 7'd0, 3'd0,
                    32'h04FD02FF, 0, 0);
         end
         begin
            @(posedge clk_i);
            #1 out_if.ready = 1'b0;
            repeat (5) @(posedge clk_i);
            #1 out_if.ready = 1'b1;
         end
      join
      drain();
      chk("bp_stalled", 32'(saw_stall), 1);
      chk("bp_cnt", 32'(mod_cnt), 6);

      for (int i = 0; i < 20; i++)
         send(32'hFFFFFFFF, 4'hF, 2'b01, 7'd0, 3'd0, 32'h0, 4, 1);
      drain();
      chk("cnt_saturate", 32'(mod_cnt), 15);

      send(32'hFFFFFFFF, 4'hF, 2'b01, 7'd0, 3'd0, 32'h0, 4, 1);
      n = 0;
      while (!out_if.valid && n < 20) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("clr_out_seen", 32'(out_if.valid), 1);
      cnt_clr = 1'b1;
      @(posedge clk_i);
      #1;
      cnt_clr = 1'b0;
      chk("cnt_clr_on_fire", 32'(mod_cnt), 0);
      drain();

      // reset mid-stream with two beats in flight
      seen = outs_seen;
      in_if.data  = 32'hFFFFFFFF;
      in_mask     = 4'hF;
      mode        = 2'b01;
      in_if.valid = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      chk("pre_rst_valid", 32'(out_if.valid), 1);
      rst_ni = 1'b0;
      in_if.valid = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_if.valid), 0);
      chk("async_rst_data", out_if.data, 0);
      chk("async_rst_ready", 32'(in_if.ready), 0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      chk("no_stale_beats", outs_seen, seen);
      chk("post_rst_cnt", 32'(mod_cnt), 0);
      chk("post_rst_ready", 32'(in_if.ready), 1);

      send(32'h7F2500FB, 4'hF, 2'b01, 7'd0, 3'd0, 32'h7F250000, 1, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vact_relu_pipe.md
Name: vact_relu_pipe

Overview:
- Multi-lane, two-stage pipelined activation unit for the vector datapath.
- Successor to the fixed 8-bit ReLU/bound clamp. Adds:
  - parametrised element width and lane count
  - a runtime-programmable bound
  - pass, ReLU, bounded-ReLU and leaky-ReLU modes
  - per-lane mask
  - valid/ready handshake
  - saturating modified-element counter for profiling
- Sits between the vector MAC result path and the vector register write-back.

Parameters:
- W, 8, element width in bits; signed two's complement.
- LANES, 4, elements processed per beat.
- SHW, 3, width of the leaky shift amount.
- CNT_W, 16, width of the modified-element counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  unit can accept a beat.
- in_data_i  in  LANES*W  packed signed elements; lane k is bits [k*W +: W].
- in_mask_i  in  LANES  1 = lane active.
- mode_i  in  2  00 pass, 01 ReLU, 10 bounded ReLU, 11 leaky ReLU.
- bound_i  in  W-1  unsigned upper bound for mode 10.
- shift_i  in  SHW  arithmetic right shift applied to negatives in mode 11.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  LANES*W  packed signed results.
- cnt_clr_i  in  1  synchronous counter clear.
- mod_cnt_o  out  CNT_W  saturating count of modified active elements.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - both stage valids cleared; out_valid_o=0; out_data_o=0; mod_cnt_o=0.
  - in_ready_o=1 from the first clock edge after release.
  - Reset asserted mid-stream drops all in-flight beats; no partial output.
- Handshake:
  - A beat transfers when valid & ready are both high.
  - in_valid_i must stay high and the data stable until accepted.
  - out_data_o is stable while out_valid_o & !out_ready_i.
- Config capture: mode_i, bound_i, shift_i and in_mask_i are sampled with the beat on input transfer. Changing them mid-stream affects only later beats.
- Latency: exactly 2 cycles from input transfer to out_valid_o, with no stall.
- Throughput: 1 beat/cycle.
- Elastic pipeline:
  - Stage s advances when its valid is low or the next stage advances.
  - in_ready_o = !s1_valid | s1_advance.
  - No combinational path from in_valid_i to out_valid_o.
  - A combinational path from out_ready_i to in_ready_o is allowed.
  - With both stages full and out_ready_i low, in_ready_o=0. No beat is lost or duplicated, and order is preserved.
- Stage 1, per lane:
  - register the neg flag (a<0) and the over flag (a > zero-extended bound).
  - register the shifted value a>>>shift, computed as a sign-preserving arithmetic shift.
- Stage 2, per active lane, result r:
  - mode 00: r=a.
  - mode 01: r = a<0 ? 0 : a.
  - mode 10: r = a<0 ? 0 : (a>bound ? bound : a). The bound is zero-extended to W. bound=0 gives all-zero output for non-positive and positive inputs alike.
  - mode 11: r = a<0 ? a>>>shift : a. shift=0 gives identity. -1>>>n stays -1. The most negative value is never overflowed.
  - Inactive lane: r=a unchanged, and the lane is never counted.
- Counter:
  - On each output transfer, add the number of active lanes where r != a.
  - Saturate at 2^CNT_W-1; never wraps.
  - cnt_clr_i has priority over a same-cycle increment: the counter goes to 0 and that beat's count is discarded.

Decomposition:
- Shared package vact_pkg holds:
  - the mode enum (VACT_PASS, VACT_RELU, VACT_BRELU, VACT_LEAKY)
  - the default W/LANES/CNT_W constants
  - a packed per-lane stage-1 struct (a, neg, over, shifted).
- One sub-module, vact_lane: the per-lane stage-1 compare/shift logic plus the stage-2 select, instantiated LANES times via generate.
- Handshake, pipeline valids and counter remain in the top module.

Test Plan:
- ReLU, mode 01, mask 1111, in {-5,0,37,127}: out {0,0,37,127} exactly 2 cycles after acceptance; mod_cnt_o increments 0->1.
- Bounded, mode 10, bound 96, in {-128,95,96,127}: out {0,95,96,96}; count +2.
- Leaky, mode 11, shift 2, in {-8,-1,-128,20}: out {-2,-1,-32,20}; count +2 (-1 is unchanged and not counted).
- Mask, mode 01, mask 0101, in {-3,-4,-5,-6}: out {0,-4,0,-6}; count +2.
- Backpressure: issue 5 back-to-back beats while out_ready_i is low for cycles 2-6. Expect in_ready_o low once 2 beats are buffered; all 5 beats emerge in order with no duplicates. mode_i is changed between beats 3 and 4, and each beat uses its own mode.
- Counter with CNT_W=4:
  - drive 20 fully-modified beats: mod_cnt_o holds 15.
  - cnt_clr_i in the same cycle as an output transfer: mod_cnt_o=0 next cycle.
  - rst_ni pulsed low mid-stream: out_valid_o drops immediately (async) and no stale beats appear afterwards.
